// File: rtl/btn_pkg.sv
// Shared types and constants for the button conditioner: channel FSM states
// and the bit positions of the four player buttons.
package btn_pkg;

    localparam int BTN_W         = 4;
    localparam int BTN_LEFT_X    = 0;
    localparam int BTN_RIGHT_X   = 1;
    localparam int BTN_LEFT_AIM  = 2;
    localparam int BTN_RIGHT_AIM = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HELD   = 2'd3
    } chan_state_e;

    // Both buttons of a left/right pair held at once: the request is contradictory.
    function automatic logic pair_clash(input logic lo_level, input logic hi_level);
        return lo_level & hi_level;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debouncer and press/repeat FSM.
// Hold-to-repeat is built when BTN_AUTOREPEAT_EN is defined; otherwise press-only.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic pulse
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q, sync_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    chan_state_e     state_q, state_d;

    always_comb begin
        sync_d = {sync_q[0], raw_in};
    end

    // The level flips on the edge the mismatch count would reach DEBOUNCE_CYCLES.
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        if (sync_q[1] != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync_q[1];
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q   <= '0;
            db_cnt_q <= '0;
            level_q  <= 1'b0;
            state_q  <= ST_IDLE;
        end else begin
            sync_q   <= sync_d;
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
            state_q  <= state_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int DLY_W = $clog2(REPEAT_DELAY + 1);
    localparam int REP_W = $clog2(REPEAT_PERIOD + 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

    always_comb begin
        state_d   = state_q;
        pulse     = 1'b0;
        dly_cnt_d = '0;
        rep_cnt_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (level_q) begin
                    state_d = ST_DELAY;
                    pulse   = 1'b1;
                end
            end
            ST_DELAY: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end else if (dly_cnt_q == DLY_LAST) begin
                    state_d = ST_REPEAT;
                    pulse   = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end else if (rep_cnt_q == REP_LAST) begin
                    pulse = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dly_cnt_q <= '0;
            rep_cnt_q <= '0;
        end else begin
            dly_cnt_q <= dly_cnt_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        pulse   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (level_q) begin
                    state_d = ST_HELD;
                    pulse   = 1'b1;
                end
            end
            ST_HELD: begin
                if (!level_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
`endif

    assign level = level_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions four raw player buttons into one-cycle step pulses with left/right
// pair arbitration. Define BTN_AUTOREPEAT_EN to enable hold-to-repeat.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BTN_W-1:0] btn_raw,
    output logic             left_x,
    output logic             right_x,
    output logic             left_aim,
    output logic             right_aim,
    output logic [BTN_W-1:0] btn_level
);

    logic [BTN_W-1:0] level_w;
    logic [BTN_W-1:0] pulse_w;
    logic [BTN_W-1:0] step_q, step_d;

    for (genvar g = 0; g < BTN_W; g++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .raw_in (btn_raw[g]),
            .level  (level_w[g]),
            .pulse  (pulse_w[g])
        );
    end

    // Channels keep their schedules during a clash; only the outputs are masked.
    always_comb begin
        step_d = pulse_w;
        if (pair_clash(level_w[BTN_LEFT_X], level_w[BTN_RIGHT_X])) begin
            step_d[BTN_LEFT_X]  = 1'b0;
            step_d[BTN_RIGHT_X] = 1'b0;
        end
        if (pair_clash(level_w[BTN_LEFT_AIM], level_w[BTN_RIGHT_AIM])) begin
            step_d[BTN_LEFT_AIM]  = 1'b0;
            step_d[BTN_RIGHT_AIM] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign left_x    = step_q[BTN_LEFT_X];
    assign right_x   = step_q[BTN_RIGHT_X];
    assign left_aim  = step_q[BTN_LEFT_AIM];
    assign right_aim = step_q[BTN_RIGHT_AIM];
    assign btn_level = level_w;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: expected pulse/level vectors come from the
// press/release timing formulas and are queued per edge, then compared.
module tb_btn_conditioner;

    localparam int D     = 4;
    localparam int RD    = 8;
    localparam int RP    = 3;
    localparam int NEVER = 1000000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic       left_x, right_x, left_aim, right_aim;
    logic [3:0] btn_level;

    always #5 clk = ~clk;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .left_x    (left_x),
        .right_x   (right_x),
        .left_aim  (left_aim),
        .right_aim (right_aim),
        .btn_level (btn_level)
    );

    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;
    int         s[4];
    int         r[4];
    logic [3:0] raw_prev;
    logic [3:0] ignore;
    bit         in_reset;
    string      tag;
    logic [7:0] expq[$];

    // Debounced level after edge e for a clean press sampled at s, release at r.
    function automatic bit lvl_at(int b, int e);
        return (e >= s[b] + D + 1) && (e < r[b] + D + 1);
    endfunction

    function automatic bit pulse_at(int b, int e);
        int p0;
        bit hit;
        p0 = s[b] + D + 2;
        if (e < p0 || e > r[b] + D + 1) return 1'b0;
        hit = (e == p0);
`ifdef BTN_AUTOREPEAT_EN
        if (e >= p0 + RD && ((e - p0 - RD) % RP) == 0) hit = 1'b1;
`endif
        if (lvl_at(b ^ 1, e - 1)) hit = 1'b0;
        return hit;
    endfunction

    function automatic logic [7:0] exp_at(int e);
        logic [7:0] v;
        v = '0;
        for (int b = 0; b < 4; b++) begin
            v[4+b] = lvl_at(b, e);
            v[b]   = pulse_at(b, e);
        end
        return v;
    endfunction

    function automatic logic [7:0] observed();
        return {btn_level, right_aim, left_aim, right_x, left_x};
    endfunction

    task automatic check(input string name, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%b expected=%b", name, edge_n, obs, expv);
        end
    endtask

    // Called just after a falling edge: drive, take one rising edge, compare.
    task automatic tick(input logic [3:0] raw);
        logic [7:0] ev;
        for (int b = 0; b < 4; b++) begin
            if (!ignore[b] && raw[b] && !raw_prev[b]) begin
                s[b] = edge_n + 1;
                r[b] = NEVER;
            end else if (!ignore[b] && !raw[b] && raw_prev[b]) begin
                r[b] = edge_n + 1;
            end
        end
        raw_prev = raw;
        btn_raw  = raw;
        expq.push_back(in_reset ? 8'h00 : exp_at(edge_n + 1));
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        ev = expq.pop_front();
        check(tag, observed(), ev);
    endtask

    task automatic ticks(input logic [3:0] raw, input int n);
        for (int i = 0; i < n; i++) tick(raw);
    endtask

    // Asserts reset between edges, holds it for n edges, releases on a falling edge.
    task automatic do_reset(input int n);
        #2;
        reset    = 1'b0;
        in_reset = 1'b1;
        #1;
        check({tag, "_async_reset"}, observed(), 8'h00);
        @(negedge clk);
        ticks(btn_raw, n);
        reset    = 1'b1;
        in_reset = 1'b0;
        raw_prev = btn_raw;
        for (int b = 0; b < 4; b++) begin
            s[b] = (btn_raw[b] && !ignore[b]) ? edge_n + 1 : NEVER;
            r[b] = NEVER;
        end
    endtask

    initial begin
        reset    = 1'b0;
        btn_raw  = 4'b0000;
        raw_prev = 4'b0000;
        ignore   = 4'b0000;
        in_reset = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s[b] = NEVER;
            r[b] = NEVER;
        end
        tag = "reset_state";
        @(negedge clk);
        do_reset(3);

        tag = "clean_press";
        ticks(4'b0001, 40);
        ticks(4'b0000, 12);
        do_reset(2);

        tag = "bounce";
        ignore = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            ticks(4'b0010, 3);
            ticks(4'b0000, 2);
        end
        ticks(4'b0000, 8);
        ignore = 4'b0000;
        do_reset(2);

        tag = "pair_conflict";
        ticks(4'b1100, 20);
        ticks(4'b1000, 20);
        ticks(4'b0000, 12);
        do_reset(2);

        tag = "reset_mid_hold";
        ticks(4'b0001, 13);
        do_reset(3);
        ticks(4'b0001, 30);
        ticks(4'b0000, 12);
        do_reset(2);

        tag = "independent_axes";
        ticks(4'b0101, 30);
        ticks(4'b0000, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
